// File: rtl/nv_nvdla_cdp_dp_nancnt_if.sv
// Valid/ready beat channel used on both sides of the CDP NaN counter.
interface nv_nvdla_cdp_dp_nancnt_if #(
  parameter int PW = 4*16+23
);
  logic [PW-1:0] pd;
  logic          pvld;
  logic          prdy;

  modport master (output pd, output pvld, input prdy);
  modport slave  (input pd, input pvld, output prdy);
endinterface

// File: rtl/nv_nvdla_cdp_dp_nancnt.sv
// CDP NaN/Inf counter: one register stage between the NaN gate and the input
// converter. Optionally zeroes fp16 NaN lanes, counts NaN/Inf elements per
// cube and publishes ping-pong buffered per-layer totals on dp2reg_done.
module nv_nvdla_cdp_dp_nancnt #(
  parameter int THROUGHPUT = 4,
  parameter int BPE        = 16,
  parameter int PW         = THROUGHPUT*BPE+23
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  nv_nvdla_cdp_dp_nancnt_if.slave  nan_preproc,
  nv_nvdla_cdp_dp_nancnt_if.master cvt_in,
  input  logic [1:0]               reg2dp_input_data_type,
  input  logic                     reg2dp_nan_to_zero,
  input  logic                     dp2reg_done,
  output logic [31:0]              dp2reg_nan_input_num,
  output logic [31:0]              dp2reg_inf_input_num
);

  localparam int DW = THROUGHPUT*BPE;
  localparam int CW = $clog2(THROUGHPUT)+1;

  function automatic logic [CW-1:0] popcount(input logic [THROUGHPUT-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < THROUGHPUT; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [CW-1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {{(33-CW){1'b0}}, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  logic                  fp16_en;
  logic                  tozero_en;
  logic [DW-1:0]         data_p0;
  logic [THROUGHPUT-1:0] nan_vec_p0;
  logic [THROUGHPUT-1:0] inf_vec_p0;
  logic [CW-1:0]         nan_beat_p0;
  logic [CW-1:0]         inf_beat_p0;
  logic [31:0]           nan_sum_p0;
  logic [31:0]           inf_sum_p0;
  logic                  accept;
  logic                  cube_end;

  logic [PW-1:0]         pd_p1;
  logic                  vld_p1;

  logic [31:0]           nan_cnt;
  logic [31:0]           inf_cnt;
  logic [31:0]           slot0_nan;
  logic [31:0]           slot0_inf;
  logic [31:0]           slot1_nan;
  logic [31:0]           slot1_inf;
  logic                  layer_flag;
  logic                  wdma_flag;

  assign nan_preproc.prdy = ~vld_p1 | cvt_in.prdy;
  assign accept           = nan_preproc.pvld & nan_preproc.prdy;
  assign cube_end         = nan_preproc.pd[DW+12] & nan_preproc.pd[DW+13] & nan_preproc.pd[DW+14];

  // ---- stage p0: lane classification, NaN zeroing and beat counts ----
  always_comb begin
    data_p0    = nan_preproc.pd[DW-1:0];
    nan_vec_p0 = '0;
    inf_vec_p0 = '0;
    for (int i = 0; i < THROUGHPUT; i++) begin
      nan_vec_p0[i] = fp16_en & (&nan_preproc.pd[i*BPE+10 +: 5]) & (|nan_preproc.pd[i*BPE +: 10]);
      inf_vec_p0[i] = fp16_en & (&nan_preproc.pd[i*BPE+10 +: 5]) & ~(|nan_preproc.pd[i*BPE +: 10]);
      if (nan_vec_p0[i] & tozero_en) begin
        data_p0[i*BPE +: BPE] = '0;
      end
    end
  end

  assign nan_beat_p0 = popcount(nan_vec_p0);
  assign inf_beat_p0 = popcount(inf_vec_p0);
  assign nan_sum_p0  = sat_add(nan_cnt, nan_beat_p0);
  assign inf_sum_p0  = sat_add(inf_cnt, inf_beat_p0);

  // Mode bits are sampled every cycle; software holds them static per layer.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      fp16_en   <= 1'b0;
      tozero_en <= 1'b0;
    end else begin
      fp16_en   <= (reg2dp_input_data_type == 2'd2);
      tozero_en <= reg2dp_nan_to_zero;
    end
  end

  // ---- stage p1: output register, holds while downstream stalls ----
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      pd_p1  <= '0;
      vld_p1 <= 1'b0;
    end else if (accept) begin
      pd_p1  <= {nan_preproc.pd[PW-1:DW], data_p0};
      vld_p1 <= 1'b1;
    end else if (cvt_in.prdy) begin
      vld_p1 <= 1'b0;
    end
  end

  assign cvt_in.pd   = pd_p1;
  assign cvt_in.pvld = vld_p1;

  // Running per-cube counters; cleared after the final beat is folded in.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      nan_cnt <= '0;
      inf_cnt <= '0;
    end else if (accept) begin
      if (cube_end) begin
        nan_cnt <= '0;
        inf_cnt <= '0;
      end else begin
        nan_cnt <= nan_sum_p0;
        inf_cnt <= inf_sum_p0;
      end
    end
  end

  // Ping-pong capture of finished layer totals, final beat included.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      slot0_nan  <= '0;
      slot0_inf  <= '0;
      slot1_nan  <= '0;
      slot1_inf  <= '0;
      layer_flag <= 1'b0;
    end else if (accept & cube_end) begin
      if (layer_flag) begin
        slot1_nan <= nan_sum_p0;
        slot1_inf <= inf_sum_p0;
      end else begin
        slot0_nan <= nan_sum_p0;
        slot0_inf <= inf_sum_p0;
      end
      layer_flag <= ~layer_flag;
    end
  end

  // Publish the next slot on done; a same-edge capture is seen next time.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dp2reg_nan_input_num <= '0;
      dp2reg_inf_input_num <= '0;
      wdma_flag            <= 1'b0;
    end else if (dp2reg_done) begin
      dp2reg_nan_input_num <= wdma_flag ? slot1_nan : slot0_nan;
      dp2reg_inf_input_num <= wdma_flag ? slot1_inf : slot0_inf;
      wdma_flag            <= ~wdma_flag;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_cdp_dp_nancnt.sv
// Scoreboard bench for nv_nvdla_cdp_dp_nancnt: stimulus pushes expected beats,
// a monitor pops and compares whenever the output transfers.
module tb_nv_nvdla_cdp_dp_nancnt;
  localparam int THROUGHPUT = 4;
  localparam int BPE        = 16;
  localparam int PW         = THROUGHPUT*BPE+23;
  localparam int PERIOD     = 10;

  logic       clk;
  logic       rst_n;
  logic [1:0] data_type;
  logic       nan_to_zero;
  logic       done;
  logic [31:0] nan_num;
  logic [31:0] inf_num;

  nv_nvdla_cdp_dp_nancnt_if #(.PW(PW)) in_if ();
  nv_nvdla_cdp_dp_nancnt_if #(.PW(PW)) out_if ();

  nv_nvdla_cdp_dp_nancnt #(.THROUGHPUT(THROUGHPUT), .BPE(BPE), .PW(PW)) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rst_n),
    .nan_preproc           (in_if),
    .cvt_in                (out_if),
    .reg2dp_input_data_type(data_type),
    .reg2dp_nan_to_zero    (nan_to_zero),
    .dp2reg_done           (done),
    .dp2reg_nan_input_num  (nan_num),
    .dp2reg_inf_input_num  (inf_num)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [PW-1:0] exp_q[$];
  time           acc_time;
  time           t_first;
  logic [PW-1:0] pt_v;
  logic [PW-1:0] b_cnt;
  logic [PW-1:0] b_one;
  logic [PW-1:0] b_one_last;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3,
                                       input logic last);
    logic [22:0] info;
    info = last ? 23'h007000 : 23'h000000;
    return {info, l3, l2, l1, l0};
  endfunction

  // Drive one beat from just after a falling edge; returns after the accepting edge.
  task automatic send(input logic [PW-1:0] pd, input logic [PW-1:0] exp, input logic d);
    logic ok;
    int   n;
    n = 0;
    @(negedge clk);
    in_if.pd   = pd;
    in_if.pvld = 1'b1;
    done       = d;
    exp_q.push_back(exp);
    forever begin
      #1;
      ok = in_if.prdy;
      @(posedge clk);
      if (ok) break;
      n++;
      if (n > 50) begin
        $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        $fatal(1);
      end
      @(negedge clk);
    end
    acc_time = $time;
  endtask

  task automatic idle();
    @(negedge clk);
    in_if.pvld = 1'b0;
    done       = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_if.pvld = 1'b0;
    done       = 1'b0;
    rst_n      = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare transferring beats against the queue, and watch stalls.
  initial begin : monitor
    logic          held;
    logic [PW-1:0] held_pd;
    logic [PW-1:0] e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_hold_pd", out_if.pd, held_pd);
          check("stall_hold_vld", PW'(out_if.pvld), PW'(1));
        end
        held = 1'b0;
        if (out_if.pvld) begin
          if (!out_if.prdy) begin
            check("stall_in_prdy", PW'(in_if.prdy), '0);
            held    = 1'b1;
            held_pd = out_if.pd;
          end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got %h expected no beat", out_if.pd);
          end else begin
            e = exp_q.pop_front();
            check("sb_beat", out_if.pd, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(200000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    rst_n       = 1'b1;
    in_if.pd    = '0;
    in_if.pvld  = 1'b0;
    out_if.prdy = 1'b1;
    data_type   = 2'd0;
    nan_to_zero = 1'b0;
    done        = 1'b0;
    #1;
    rst_n = 1'b0;
    #(PERIOD*2);

    // Reset state
    check("rst_out_vld", PW'(out_if.pvld), '0);
    check("rst_out_pd", out_if.pd, '0);
    check("rst_in_prdy", PW'(in_if.prdy), PW'(1));
    check("rst_nan_num", PW'(nan_num), '0);
    check("rst_inf_num", PW'(inf_num), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Passthrough in non-fp16 mode, back to back
    data_type   = 2'd0;
    nan_to_zero = 1'b1;
    repeat (2) @(negedge clk);
    t_first = 0;
    for (int b = 0; b < 100; b++) begin
      pt_v[PW-1:64] = 23'($urandom);
      for (int i = 0; i < 4; i++) begin
        pt_v[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'h7C01 : 16'($urandom);
      end
      send(pt_v, pt_v, 1'b0);
      if (b == 0) t_first = acc_time;
    end
    idle();
    check("pt_no_bubble", PW'(acc_time - t_first), PW'(99*PERIOD));
    pulse_done();
    check("pt_nan_num", PW'(nan_num), '0);
    check("pt_inf_num", PW'(inf_num), '0);

    // NaN zeroing on / off
    do_reset();
    data_type   = 2'd2;
    nan_to_zero = 1'b1;
    repeat (2) @(negedge clk);
    send(mk(16'h7E00, 16'h7C00, 16'h3C00, 16'hFC01, 1'b0),
         mk(16'h0000, 16'h7C00, 16'h3C00, 16'h0000, 1'b0), 1'b0);
    idle();
    nan_to_zero = 1'b0;
    repeat (2) @(negedge clk);
    send(mk(16'h7E00, 16'h7C00, 16'h3C00, 16'hFC01, 1'b0),
         mk(16'h7E00, 16'h7C00, 16'h3C00, 16'hFC01, 1'b0), 1'b0);
    idle();

    // Layer count, cube_end on a NaN beat
    do_reset();
    data_type   = 2'd2;
    nan_to_zero = 1'b0;
    repeat (2) @(negedge clk);
    b_cnt = mk(16'h7C01, 16'h7C00, 16'hFC00, 16'h3C00, 1'b0);
    for (int b = 0; b < 10; b++) begin
      pt_v = mk(16'h7C01, 16'h7C00, 16'hFC00, 16'h3C00, (b == 9));
      send(pt_v, pt_v, 1'b0);
    end
    idle();
    #1;
    check("layer_run_nan", PW'(dut.nan_cnt), '0);
    check("layer_run_inf", PW'(dut.inf_cnt), '0);
    pulse_done();
    check("layer_nan_num", PW'(nan_num), PW'(10));
    check("layer_inf_num", PW'(inf_num), PW'(20));

    // Backpressure: 7 stalled cycles in the middle of the same layer
    do_reset();
    fork
      begin
        repeat (4) @(negedge clk);
        out_if.prdy = 1'b0;
        repeat (7) @(negedge clk);
        out_if.prdy = 1'b1;
      end
    join_none
    for (int b = 0; b < 10; b++) begin
      pt_v = mk(16'h7C01, 16'h7C00, 16'hFC00, 16'h3C00, (b == 9));
      send(pt_v, pt_v, 1'b0);
    end
    idle();
    repeat (2) @(negedge clk);
    pulse_done();
    check("bp_nan_num", PW'(nan_num), PW'(10));
    check("bp_inf_num", PW'(inf_num), PW'(20));

    // Ping-pong slots and done coinciding with cube_end
    do_reset();
    b_one      = mk(16'h7C01, 16'h3C00, 16'h3C00, 16'h3C00, 1'b0);
    b_one_last = mk(16'h7C01, 16'h3C00, 16'h3C00, 16'h3C00, 1'b1);
    send(b_one, b_one, 1'b0);
    send(b_one, b_one, 1'b0);
    send(b_one_last, b_one_last, 1'b0);
    for (int b = 0; b < 4; b++) send(b_one, b_one, 1'b0);
    send(b_one_last, b_one_last, 1'b1);
    idle();
    #1;
    check("pp_done_with_b_end", PW'(nan_num), PW'(3));
    check("pp_inf_zero", PW'(inf_num), '0);
    pulse_done();
    check("pp_second_done", PW'(nan_num), PW'(5));
    send(b_one, b_one, 1'b0);
    send(b_one_last, b_one_last, 1'b1);
    idle();
    #1;
    check("pp_same_slot_old", PW'(nan_num), PW'(3));
    pulse_done();
    check("pp_slot1_again", PW'(nan_num), PW'(5));
    pulse_done();
    check("pp_slot0_new", PW'(nan_num), PW'(2));

    // Asynchronous reset in the middle of a layer
    for (int b = 0; b < 4; b++) send(b_one, b_one, 1'b0);
    @(negedge clk);
    in_if.pd   = b_one;
    in_if.pvld = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_out_vld", PW'(out_if.pvld), '0);
    check("mid_rst_out_pd", out_if.pd, '0);
    check("mid_rst_in_prdy", PW'(in_if.prdy), PW'(1));
    check("mid_rst_nan_num", PW'(nan_num), '0);
    check("mid_rst_nan_cnt", PW'(dut.nan_cnt), '0);
    in_if.pvld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      pt_v = (b == 7) ? b_one_last : b_one;
      send(pt_v, pt_v, 1'b0);
    end
    idle();
    pulse_done();
    check("post_rst_nan_num", PW'(nan_num), PW'(8));
    check("post_rst_inf_num", PW'(inf_num), '0);

    repeat (3) @(negedge clk);
    check("sb_drained", PW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
